// File: rtl/x2050lsseq.sv
// x2050lsseq -- local-store address sequencer for the 2050 CPU/channel path.
//
// Turns the ROS word's WS/SS/E fields and the J/MD registers into a
// registered local-store address, function bits and read/write strobes.
// A small state machine performs the channel break-in (save R then L to the
// backup slots, enter I/O mode) and break-out (restore R then L, return to
// CPU mode).
//
// Parameters:
//   AW       local-store address width (>= 6)
//   CH_BITS  log2 of the channel count; each channel owns 4 words
//   CH_BASE  first word of the channel area
//   BK_BASE  first of 4 backup words (R, L, interrupt buffer, buffer #3)
//
// Ports:
//   i_clk        clock
//   i_reset      asynchronous active-low reset
//   i_ws         WS field, local-store address select
//   i_ss         SS field (14 or 39 enables the LS function bits)
//   i_e          E field
//   i_j_reg      J register
//   i_md_reg     MD register
//   i_ch         active channel number
//   i_cpu_wr     CPU cycle writes local store
//   i_io_wr      I/O cycle writes local store
//   i_break_req  channel break-in request
//   i_break_end  channel break-out request
//   i_stall      freeze state and all output registers this cycle
//   o_lsa        registered local-store address
//   o_lsfn       registered local-store function bits
//   o_ls_we      registered write strobe
//   o_ls_re      registered read strobe
//   o_io_mode    high in I/O mode and while restoring
//   o_break_ack  one active cycle on the first I/O cycle after a save
//   o_busy       high during the save and restore states
module x2050lsseq #(
  parameter int AW      = 6,
  parameter int CH_BITS = 2,
  parameter int CH_BASE = 0,
  parameter int BK_BASE = 44
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [2:0]         i_ws,
  input  logic [5:0]         i_ss,
  input  logic [3:0]         i_e,
  input  logic [3:0]         i_j_reg,
  input  logic [3:0]         i_md_reg,
  input  logic [CH_BITS-1:0] i_ch,
  input  logic               i_cpu_wr,
  input  logic               i_io_wr,
  input  logic               i_break_req,
  input  logic               i_break_end,
  input  logic               i_stall,
  output logic [AW-1:0]      o_lsa,
  output logic [1:0]         o_lsfn,
  output logic               o_ls_we,
  output logic               o_ls_re,
  output logic               o_io_mode,
  output logic               o_break_ack,
  output logic               o_busy
);

  typedef enum logic [2:0] {
    ST_CPU,
    ST_SAVE_R,
    ST_SAVE_L,
    ST_IO,
    ST_RST_R,
    ST_RST_L
  } state_t;

  localparam logic [AW-1:0] LP_BK_R = AW'(BK_BASE);
  localparam logic [AW-1:0] LP_BK_L = AW'(BK_BASE + 1);
  localparam logic [AW-1:0] LP_CH   = AW'(CH_BASE);

  state_t          r_state;
  state_t          w_next;

  logic [1:0]      w_lsfn;
  logic [5:0]      w_cpu6;
  logic [AW-1:0]   w_cpu_lsa;
  logic [AW-1:0]   w_io_lsa;

  logic [AW-1:0]   w_lsa;
  logic [1:0]      w_lsfn_o;
  logic            w_we;
  logic            w_re;
  logic            w_io_mode;
  logic            w_ack;
  logic            w_busy;

  // Next state. Break requests are only honoured in the state that owns
  // them, so req wins in CPU and end wins in IO when both are asserted.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_CPU:    w_next = i_break_req ? ST_SAVE_R : ST_CPU;
      ST_SAVE_R: w_next = ST_SAVE_L;
      ST_SAVE_L: w_next = ST_IO;
      ST_IO:     w_next = i_break_end ? ST_RST_R : ST_IO;
      ST_RST_R:  w_next = ST_RST_L;
      ST_RST_L:  w_next = ST_CPU;
      default:   w_next = ST_CPU;
    endcase
  end

  // Function bits are only meaningful for the two SS codes that select them.
  always_comb begin
    w_lsfn = 2'b00;
    if (i_ss == 6'd14 || i_ss == 6'd39) begin
      w_lsfn = i_e[1:0];
    end
  end

  // CPU address map, built as a 6-bit word and zero-extended.
  always_comb begin
    w_cpu6 = '0;
    unique case (i_ws)
      3'd0:    w_cpu6 = 6'd0;
      3'd1:    w_cpu6 = 6'd17;
      3'd2:    w_cpu6 = 6'd18;
      3'd3:    w_cpu6 = {2'b01, i_e};
      3'd4:    w_cpu6 = {w_lsfn, i_j_reg};
      3'd5:    w_cpu6 = {w_lsfn, i_j_reg[3:1], 1'b1};
      3'd6:    w_cpu6 = {w_lsfn, i_md_reg};
      3'd7:    w_cpu6 = {w_lsfn, i_md_reg[3:1], 1'b1};
      default: w_cpu6 = 6'd0;
    endcase
  end

  assign w_cpu_lsa = AW'(w_cpu6);

  // I/O address map: low WS codes hit the backup slots, high codes hit the
  // active channel's 4-word block. All sums wrap at AW bits.
  always_comb begin
    if (i_ws[2]) begin
      w_io_lsa = LP_CH + (AW'(i_ch) << 2) + AW'(i_ws[1:0]);
    end else begin
      w_io_lsa = LP_BK_R + AW'(i_ws[1:0]);
    end
  end

  // Output values are derived from the state being entered, so the
  // registered outputs line up with the registered state.
  always_comb begin
    w_lsa     = '0;
    w_lsfn_o  = 2'b00;
    w_we      = 1'b0;
    w_re      = 1'b0;
    w_io_mode = 1'b0;
    w_ack     = 1'b0;
    w_busy    = 1'b0;
    unique case (w_next)
      ST_CPU: begin
        w_lsa    = w_cpu_lsa;
        w_lsfn_o = w_lsfn;
        if (i_ws != 3'd0) begin
          w_we = i_cpu_wr;
          w_re = !i_cpu_wr;
        end
      end
      ST_SAVE_R: begin
        w_lsa  = LP_BK_R;
        w_we   = 1'b1;
        w_busy = 1'b1;
      end
      ST_SAVE_L: begin
        w_lsa  = LP_BK_L;
        w_we   = 1'b1;
        w_busy = 1'b1;
      end
      ST_IO: begin
        w_lsa     = w_io_lsa;
        w_lsfn_o  = w_lsfn;
        w_we      = i_io_wr;
        w_re      = !i_io_wr;
        w_io_mode = 1'b1;
        w_ack     = (r_state == ST_SAVE_L);
      end
      ST_RST_R: begin
        w_lsa     = LP_BK_R;
        w_re      = 1'b1;
        w_io_mode = 1'b1;
        w_busy    = 1'b1;
      end
      ST_RST_L: begin
        w_lsa     = LP_BK_L;
        w_re      = 1'b1;
        w_io_mode = 1'b1;
        w_busy    = 1'b1;
      end
      default: begin
        w_lsa = '0;
      end
    endcase
  end

  // Stall freezes every register, including the one-cycle ack.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= ST_CPU;
      o_lsa       <= '0;
      o_lsfn      <= '0;
      o_ls_we     <= 1'b0;
      o_ls_re     <= 1'b0;
      o_io_mode   <= 1'b0;
      o_break_ack <= 1'b0;
      o_busy      <= 1'b0;
    end else if (!i_stall) begin
      r_state     <= w_next;
      o_lsa       <= w_lsa;
      o_lsfn      <= w_lsfn_o;
      o_ls_we     <= w_we;
      o_ls_re     <= w_re;
      o_io_mode   <= w_io_mode;
      o_break_ack <= w_ack;
      o_busy      <= w_busy;
    end
  end

endmodule

// File: tb/tb_x2050lsseq.sv
module tb_x2050lsseq;

  localparam int AW      = 7;
  localparam int CH_BITS = 3;
  localparam int CH_BASE = 16;
  localparam int BK_BASE = 44;

  logic               clk;
  logic               rst;
  logic [2:0]         ws;
  logic [5:0]         ss;
  logic [3:0]         e;
  logic [3:0]         j;
  logic [3:0]         md;
  logic [CH_BITS-1:0] ch;
  logic               cpu_wr;
  logic               io_wr;
  logic               breq;
  logic               bend;
  logic               stall;
  logic [AW-1:0]      lsa;
  logic [1:0]         lsfn;
  logic               we;
  logic               re;
  logic               io_mode;
  logic               ack;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode as a plain phase number plus expected outputs.
  // 0 cpu, 1 saving R, 2 saving L, 3 io, 4 restoring R, 5 restoring L
  int m_ph;
  int m_lsa, m_lsfn, m_we, m_re, m_io, m_ack, m_busy;

  x2050lsseq #(
    .AW      (AW),
    .CH_BITS (CH_BITS),
    .CH_BASE (CH_BASE),
    .BK_BASE (BK_BASE)
  ) dut (
    .i_clk       (clk),
    .i_reset     (rst),
    .i_ws        (ws),
    .i_ss        (ss),
    .i_e         (e),
    .i_j_reg     (j),
    .i_md_reg    (md),
    .i_ch        (ch),
    .i_cpu_wr    (cpu_wr),
    .i_io_wr     (io_wr),
    .i_break_req (breq),
    .i_break_end (bend),
    .i_stall     (stall),
    .o_lsa       (lsa),
    .o_lsfn      (lsfn),
    .o_ls_we     (we),
    .o_ls_re     (re),
    .o_io_mode   (io_mode),
    .o_break_ack (ack),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_lsa = 0; m_lsfn = 0; m_we = 0; m_re = 0;
    m_io = 0; m_ack = 0; m_busy = 0;
  endtask

  function automatic int fn_bits();
    return (ss == 6'd14 || ss == 6'd39) ? int'(e[1:0]) : 0;
  endfunction

  function automatic int cpu_addr();
    int f;
    f = fn_bits();
    case (ws)
      3'd0: return 0;
      3'd1: return 17;
      3'd2: return 18;
      3'd3: return 16 + int'(e);
      3'd4: return f * 16 + int'(j);
      3'd5: return f * 16 + (int'(j) | 1);
      3'd6: return f * 16 + int'(md);
      default: return f * 16 + (int'(md) | 1);
    endcase
  endfunction

  function automatic int io_addr();
    if (ws < 3'd4) return (BK_BASE + int'(ws)) % (1 << AW);
    return (CH_BASE + 4 * int'(ch) + int'(ws) - 4) % (1 << AW);
  endfunction

  task automatic model_edge();
    int old;
    if (stall) return;
    old = m_ph;
    if (old == 0) m_ph = breq ? 1 : 0;
    else if (old == 3) m_ph = bend ? 4 : 3;
    else m_ph = (old + 1) % 6;
    m_lsa = 0; m_lsfn = 0; m_we = 0; m_re = 0; m_io = 0; m_ack = 0; m_busy = 0;
    if (m_ph == 0) begin
      m_lsa = cpu_addr(); m_lsfn = fn_bits();
      if (ws != 3'd0) begin m_we = int'(cpu_wr); m_re = int'(!cpu_wr); end
    end else if (m_ph == 3) begin
      m_lsa = io_addr(); m_lsfn = fn_bits();
      m_we = int'(io_wr); m_re = int'(!io_wr); m_io = 1;
      m_ack = (old == 2) ? 1 : 0;
    end else begin
      m_lsa  = BK_BASE + ((m_ph == 2 || m_ph == 5) ? 1 : 0);
      m_we   = (m_ph <= 2) ? 1 : 0;
      m_re   = (m_ph >= 4) ? 1 : 0;
      m_io   = (m_ph >= 4) ? 1 : 0;
      m_busy = 1;
    end
  endtask

  task automatic check_all();
    check("lsa",     32'(lsa),     32'(m_lsa));
    check("lsfn",    32'(lsfn),    32'(m_lsfn));
    check("we",      32'(we),      32'(m_we));
    check("re",      32'(re),      32'(m_re));
    check("io_mode", 32'(io_mode), 32'(m_io));
    check("ack",     32'(ack),     32'(m_ack));
    check("busy",    32'(busy),    32'(m_busy));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  initial begin
    int cpu_exp[7];
    cpu_exp = '{17, 18, 21, 25, 25, 22, 23};
    ws = 0; ss = 0; e = 0; j = 0; md = 0; ch = 0;
    cpu_wr = 0; io_wr = 0; breq = 0; bend = 0; stall = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;

    // CPU address map
    e = 4'd5; j = 4'd9; md = 4'd6; ss = 6'd14;
    for (int i = 1; i <= 7; i++) begin
      ws = 3'(i);
      cyc();
      check("cpu_map", 32'(lsa), 32'(cpu_exp[i-1]));
      check("cpu_lsfn", 32'(lsfn), 32'd1);
    end

    // Break-in
    breq = 1'b1; cyc();
    check("save_r_lsa", 32'(lsa), 32'd44);
    breq = 1'b0; cyc();
    check("save_l_lsa", 32'(lsa), 32'd45);
    ch = 3'd5; io_wr = 1'b1; ws = 3'd4; cyc();
    check("io_ack", 32'(ack), 32'd1);
    for (int i = 5; i <= 7; i++) begin
      ws = 3'(i); cyc();
      check("io_ch", 32'(lsa), 32'(36 + i - 5 + 1));
      check("io_ack_drop", 32'(ack), 32'd0);
    end
    ws = 3'd2; cyc();
    check("io_bk", 32'(lsa), 32'd46);

    // Break-out, then a stray break_end in CPU
    io_wr = 1'b0; bend = 1'b1; cyc();
    check("rst_r_lsa", 32'(lsa), 32'd44);
    bend = 1'b0; cyc();
    check("rst_l_lsa", 32'(lsa), 32'd45);
    ws = 3'd1; cyc();
    check("back_cpu", 32'(io_mode), 32'd0);
    bend = 1'b1; cyc(); cyc();
    bend = 1'b0;

    // Stall during SAVE_L
    breq = 1'b1; cyc();
    breq = 1'b0; cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("stall_lsa", 32'(lsa), 32'd45);
      check("stall_we", 32'(we), 32'd1);
    end
    stall = 1'b0; cyc();
    check("stall_io", 32'(io_mode), 32'd1);

    // Reset during RST_R
    bend = 1'b1; cyc();
    bend = 1'b0;
    rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #2 rst = 1'b1;
    ws = 3'd0; cyc();
    check("no_restore_lsa", 32'(lsa), 32'd0);
    check("no_restore_re", 32'(re), 32'd0);

    // Break request held through the restore
    breq = 1'b1; cyc(); cyc(); cyc();
    bend = 1'b1; cyc();
    bend = 1'b0; cyc(); cyc(); cyc();
    check("reenter", 32'(busy), 32'd1);
    breq = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      ws     = 3'($urandom_range(0, 7));
      ss     = ($urandom_range(0, 2) == 0) ? 6'd39 :
               ($urandom_range(0, 1) == 0) ? 6'd14 : 6'($urandom);
      e      = 4'($urandom);
      j      = 4'($urandom);
      md     = 4'($urandom);
      ch     = CH_BITS'($urandom);
      cpu_wr = 1'($urandom);
      io_wr  = 1'($urandom);
      breq   = ($urandom_range(0, 3) == 0);
      bend   = ($urandom_range(0, 3) == 0);
      stall  = ($urandom_range(0, 5) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/x2050lsseq.md
# x2050lsseq

Parametrised local-store address sequencer for the 2050 CPU/channel datapath. It replaces purely combinational local-store address decode with registered address and strobe generation. It sizes the channel area from a channel-count parameter and adds a hardware break-in/break-out state machine that saves and restores the CPU R and L registers through the backup slots. It sits between the ROS word decode (WS/SS fields, J, MD, E) and the local-store array.

## Interface
Parameters:
- AW, 6, local-store address width; must be ≥ 6.
- CH_BITS, 2, log2 of channel count. Channel area is 4 words per channel.
- CH_BASE, 0, first word of the channel area.
- BK_BASE, 44, first of 4 backup words: R backup, L backup, interrupt buffer, buffer #3.

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, asynchronous, active-low
- i_ws  in  3  WS field (LS address select)
- i_ss  in  6  SS field
- i_e  in  4  E field
- i_j_reg  in  4  J register
- i_md_reg  in  4  MD register
- i_ch  in  CH_BITS  active channel
- i_cpu_wr  in  1  CPU cycle writes LS
- i_io_wr  in  1  I/O cycle writes LS
- i_break_req  in  1  channel break-in request
- i_break_end  in  1  channel break-out request
- i_stall  in  1  freeze sequencer this cycle
- o_lsa  out  AW  registered LS address
- o_lsfn  out  2  registered LS function bits
- o_ls_we  out  1  registered LS write strobe
- o_ls_re  out  1  registered LS read strobe
- o_io_mode  out  1  1 while in I/O or a restore state
- o_break_ack  out  1  break-in complete, one active cycle
- o_busy  out  1  in a save or restore state

## Operation
- States: CPU, SAVE_R, SAVE_L, IO, RST_R, RST_L. All outputs are registered from the next state plus the current inputs.
- lsfn = i_e[1:0] when i_ss is 14 or 39; otherwise 0.
- CPU map, zero-extended to AW:
  - ws0 → 0, no strobe.
  - ws1 → 17.
  - ws2 → 18.
  - ws3 → {01,e}.
  - ws4 → {lsfn,j}.
  - ws5 → {lsfn,j[3:1],1}.
  - ws6 → {lsfn,md}.
  - ws7 → {lsfn,md[3:1],1}.
- IO map:
  - ws0–3 → BK_BASE+ws.
  - ws4–7 → CH_BASE + 4·i_ch + (ws−4).
- Strobes in CPU/IO:
  - o_ls_we = wr.
  - o_ls_re = !wr.
  - Both are 0 for CPU ws0.
  - wr is i_cpu_wr in CPU and i_io_wr in IO.
- Transitions (evaluated only when i_stall=0):
  - CPU → SAVE_R on i_break_req.
  - SAVE_R → SAVE_L.
  - SAVE_L → IO.
  - IO → RST_R on i_break_end.
  - RST_R → RST_L.
  - RST_L → CPU.
- Save and restore addresses and strobes:
  - SAVE_R: o_lsa=BK_BASE, we=1.
  - SAVE_L: o_lsa=BK_BASE+1, we=1.
  - RST_R: o_lsa=BK_BASE, re=1.
  - RST_L: o_lsa=BK_BASE+1, re=1.
  - i_ws, i_cpu_wr and i_io_wr are ignored in these four states.
- Ignored requests:
  - i_break_req outside CPU.
  - i_break_end outside IO.
- o_break_ack is 1 in the first IO cycle after SAVE_L only.
- o_io_mode is 1 in IO, RST_R and RST_L.
- o_busy is 1 in SAVE_*/RST_*.
- Channel address arithmetic is AW bits wide; overflow truncates.

## Timing
- Reset (i_reset=0): state CPU immediately. All outputs 0, o_lsa=0.
- Reset mid-sequence abandons the save/restore; no restore is performed.
- Address latency is 1 clock: o_lsa at edge k+1 reflects the inputs sampled at edge k.
- Break-in: i_break_req sampled at edge k gives:
  - SAVE_R after k.
  - SAVE_L after k+1.
  - IO with ack after k+2.
  - Ack drops after k+3 if not stalled.
- Break-out: i_break_end sampled at edge k gives:
  - RST_R after k.
  - RST_L after k+1.
  - CPU after k+2 (o_io_mode=0).
- i_stall=1 holds the state and every output register, including o_break_ack, unchanged.
- Simultaneous i_break_req and i_break_end:
  - In CPU, req is taken.
  - In IO, end is taken.
- i_break_req held high through RST_L re-enters SAVE_R one cycle after returning to CPU.

## Test plan
- Reset release, CPU mode, ws1..7 with e=5, j=9, md=6, ss=14 → o_lsa one cycle later: 17, 18, 21, 25, 25, 22, 23; o_lsfn=1.
- Pulse i_break_req → o_lsa 44/we, then 45/we, then IO with o_break_ack=1 for exactly 1 cycle; o_busy=1 for 2 cycles.
- In IO with CH_BITS=3, CH_BASE=16, AW=7, ch=5: ws4..7 → 36..39; ws2 → 46; i_io_wr=1 gives we=1, re=0.
- Assert i_break_end → 44/re, then 45/re, then CPU with o_io_mode=0. Assert i_break_end again in CPU → no effect.
- i_stall=1 for 3 cycles during SAVE_L → o_lsa stays 45 and we stays 1; IO is entered only after stall drops.
- Assert i_reset=0 during RST_R → outputs 0 asynchronously; after release, state is CPU and no 45 read occurs.
